letc_core_lsu: RTL

Load/store unit feeding the core data memory subsystem (DMSS) request port and consuming its response and commit ports.
- Issues word-granular requests to DMSS.
- Tracks each op through three pipeline slots aligned with DMSS stages 0/1/2.
- Extracts and sign/zero-extends load results.
- Builds full-word store data by read-modify-write merge, because DMSS writes whole words only.

---
 rtl/letc_core_lsu.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/letc_core_lsu.sv
// letc_core_lsu
// Load/store unit sitting between the E stage and the data memory subsystem
// (DMSS). Each accepted op is tracked through three slots that move in
// lockstep with DMSS stages 0/1/2. Loads are extracted and extended at WB.
// Stores read the target word first, then write back a fully merged word,
// because DMSS only writes whole words.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   e_*                      memory op presented by E (valid/stall/type/size/addr/data)
//   e_misaligned, e_accept   combinational issue status back to E
//   lsu_busy                 core must stall E while DMSS stage 1 is held
//   dmss0_req_*              stage-0 request (load/store/addr/stall)
//   dmss1_rsp_*              stage-1 response word and ready
//   wb_commit                instruction in WB retires
//   dmss2_req_*              stage-2 store commit and merged store word
//   wb_load_valid/_data      extended load result in WB
module letc_core_lsu #(
    parameter logic [31:0] TRACK_RESET_ADDR = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        e_valid,
    input  logic        e_stall,
    input  logic        e_load,
    input  logic        e_store,
    input  logic [1:0]  e_size,
    input  logic        e_unsigned,
    input  logic [31:0] e_addr,
    input  logic [31:0] e_store_data,
    output logic        e_misaligned,
    output logic        e_accept,
    output logic        lsu_busy,
    output logic        dmss0_req_load,
    output logic        dmss0_req_store,
    output logic [31:0] dmss0_req_addr,
    output logic        dmss0_req_stall,
    input  logic [31:0] dmss1_rsp_load_data,
    input  logic        dmss1_rsp_ready,
    input  logic        wb_commit,
    output logic        dmss2_req_commit,
    output logic [31:0] dmss2_req_store_data,
    output logic        wb_load_valid,
    output logic [31:0] wb_load_data
);

    typedef struct packed {
        logic        valid;
        logic        store;
        logic [1:0]  size;
        logic        zext;
        logic [1:0]  addr;
        logic [31:0] store_data;
    } slot_t;

    localparam slot_t SLOT_RESET = {1'b0, 1'b0, 2'd0, 1'b0, TRACK_RESET_ADDR[1:0], 32'd0};

    slot_t       s1;
    slot_t       s2;
    slot_t       s3;
    slot_t       e_slot;
    logic [31:0] s3_word;
    logic        misaligned_raw;
    logic        issue;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [31:0] merged_word;

    // Size code 3 is treated as a word access everywhere.
    always_comb begin
        misaligned_raw = 1'b0;
        if (e_size == 2'd1) begin
            misaligned_raw = e_addr[0];
        end else if (e_size != 2'd0) begin
            misaligned_raw = (e_addr[1:0] != 2'b00);
        end
    end

    assign issue = e_valid & (e_load | e_store) & ~e_stall & ~misaligned_raw & dmss1_rsp_ready;

    // Outputs are forced low while reset is held; only the stall/busy pair
    // keeps tracking DMSS readiness so the core still sees a held stage 1.
    // Stores also issue a read so the merge has the current word.
    assign e_misaligned    = ~rst & misaligned_raw;
    assign e_accept        = ~rst & issue;
    assign dmss0_req_load  = ~rst & issue;
    assign dmss0_req_store = ~rst & issue & e_store;
    assign dmss0_req_addr  = rst ? 32'd0 : e_addr;
    assign dmss0_req_stall = ~dmss1_rsp_ready;
    assign lsu_busy        = ~dmss1_rsp_ready;

    always_comb begin
        e_slot            = SLOT_RESET;
        e_slot.valid      = issue;
        e_slot.store      = e_store;
        e_slot.size       = e_size;
        e_slot.zext       = e_unsigned;
        e_slot.addr       = e_addr[1:0];
        e_slot.store_data = e_store_data;
    end

    // Slots advance only when DMSS stage 1 is ready, mirroring the DMSS hold.
    // While held, s3 turns into a bubble so the store DMSS stage 2 keeps
    // seeing is not committed a second time. The response word is captured
    // together with the op leaving s2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= SLOT_RESET;
            s2      <= SLOT_RESET;
            s3      <= SLOT_RESET;
            s3_word <= 32'd0;
        end else if (dmss1_rsp_ready) begin
            s1      <= e_slot;
            s2      <= s1;
            s3      <= s2;
            s3_word <= dmss1_rsp_load_data;
        end else begin
            s3.valid <= 1'b0;
        end
    end

    assign byte_sel = s3_word[{s3.addr, 3'b000} +: 8];
    assign half_sel = s3_word[{s3.addr[1], 4'b0000} +: 16];

    always_comb begin
        case (s3.size)
            2'd0:    load_ext = {{24{~s3.zext & byte_sel[7]}}, byte_sel};
            2'd1:    load_ext = {{16{~s3.zext & half_sel[15]}}, half_sel};
            default: load_ext = s3_word;
        endcase
    end

    // Store merge: replace only the addressed lanes of the word read back
    // from DMSS with the right-aligned store operand moved into place.
    always_comb begin
        lane_shift = (s3.size == 2'd1) ? {s3.addr[1], 4'b0000} : {s3.addr, 3'b000};
        case (s3.size)
            2'd0:    lane_mask = 32'h0000_00FF << lane_shift;
            2'd1:    lane_mask = 32'h0000_FFFF << lane_shift;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        merged_word = (s3_word & ~lane_mask) | ((s3.store_data << lane_shift) & lane_mask);
    end

    assign wb_load_valid        = ~rst & s3.valid & ~s3.store;
    assign wb_load_data         = rst ? 32'd0 : load_ext;
    assign dmss2_req_commit     = ~rst & s3.valid & s3.store & wb_commit;
    assign dmss2_req_store_data = rst ? 32'd0 : merged_word;

endmodule
